// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with count-based full/empty, programmable almost flags,
// sticky overflow/underflow, and a choice of FWFT or one-cycle registered reads.
module sync_fifo_flags #(
  parameter int DATA_WIDTH         = 8,
  parameter int DEPTH              = 8,
  parameter int ALMOST_FULL_LEVEL  = 6,
  parameter int ALMOST_EMPTY_LEVEL = 2,
  parameter bit FWFT               = 1'b1,
  localparam int CW                = $clog2(DEPTH + 1),
  localparam int AW                = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_q, count_next;
  logic                  wr_ok, rd_ok;

  // Explicit wrap so non-power-of-2 depths never address past the last entry.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_empty = (count_q <= CW'(ALMOST_EMPTY_LEVEL));
  assign almost_full  = (count_q >= CW'(ALMOST_FULL_LEVEL));
  assign count        = count_q;

  // A read frees a slot in the same cycle, so a full FIFO can still take a write.
  assign rd_ok = read & ~empty;
  assign wr_ok = write & (~full | rd_ok);

  always_comb begin
    count_next = count_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_next = count_q + CW'(1);
      2'b01:   count_next = count_q - CW'(1);
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= next_ptr(wr_ptr);
      if (rd_ok) rd_ptr <= next_ptr(rd_ptr);
      count_q <= count_next;
      if (write & ~wr_ok) overflow  <= 1'b1;
      if (read & empty)   underflow <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (!reset && wr_ok) mem[wr_ptr] <= data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      assign data_out  = empty ? '0 : mem[rd_ptr];
      assign valid_out = ~empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  vld_q;
      always_ff @(posedge clock) begin
        if (reset) begin
          dout_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          vld_q <= rd_ok;
          if (rd_ok) dout_q <= mem[rd_ptr];
        end
      end
      assign data_out  = dout_q;
      assign valid_out = vld_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench: three FIFO configurations, directed stimulus pushes expected
// words, per-instance monitors pop and compare whenever a word is delivered.
module tb_sync_fifo_flags;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       wr [3];
  logic       rd [3];
  logic [7:0] din [3];

  // inst 0: DEPTH=5 FWFT ; inst 1: DEPTH=8 FWFT ; inst 2: DEPTH=8 registered
  logic [7:0] d0, d1, d2;
  logic       v0, v1, v2, e0, e1, e2, f0, f1, f2;
  logic       ae0, ae1, ae2, af0, af1, af2, ov0, ov1, ov2, un0, un1, un2;
  logic [2:0] c0;
  logic [3:0] c1, c2;

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(5), .ALMOST_FULL_LEVEL(4),
                    .ALMOST_EMPTY_LEVEL(1), .FWFT(1'b1)) u_a (
    .clock(clock), .reset(reset), .write(wr[0]), .data_in(din[0]), .read(rd[0]),
    .data_out(d0), .valid_out(v0), .empty(e0), .full(f0), .almost_empty(ae0),
    .almost_full(af0), .count(c0), .overflow(ov0), .underflow(un0));

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(8), .ALMOST_FULL_LEVEL(6),
                    .ALMOST_EMPTY_LEVEL(2), .FWFT(1'b1)) u_b (
    .clock(clock), .reset(reset), .write(wr[1]), .data_in(din[1]), .read(rd[1]),
    .data_out(d1), .valid_out(v1), .empty(e1), .full(f1), .almost_empty(ae1),
    .almost_full(af1), .count(c1), .overflow(ov1), .underflow(un1));

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(8), .ALMOST_FULL_LEVEL(6),
                    .ALMOST_EMPTY_LEVEL(2), .FWFT(1'b0)) u_c (
    .clock(clock), .reset(reset), .write(wr[2]), .data_in(din[2]), .read(rd[2]),
    .data_out(d2), .valid_out(v2), .empty(e2), .full(f2), .almost_empty(ae2),
    .almost_full(af2), .count(c2), .overflow(ov2), .underflow(un2));

  int checks = 0;
  int errors = 0;
  int pops0 = 0, pops1 = 0, pops2 = 0;
  logic [7:0] q0[$], q1[$], q2[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon_cmp(input string name, input logic [7:0] act, inout logic [7:0] q[$],
                         inout int pops);
    logic [7:0] exp;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected word 0x%0h, scoreboard empty", name, act);
    end else begin
      exp = q.pop_front();
      pops++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // FWFT delivers a word when a read is accepted; registered mode when valid_out rises.
  always @(negedge clock) if (!reset && rd[0] && !e0) mon_cmp("mon0", d0, q0, pops0);
  always @(negedge clock) if (!reset && rd[1] && !e1) mon_cmp("mon1", d1, q1, pops1);
  always @(negedge clock) if (!reset && v2)           mon_cmp("mon2", d2, q2, pops2);

  // Called at posedge+1; holds inputs across one active edge.
  task automatic step(input int i, input bit w, input logic [7:0] d, input bit r);
    wr[i] = w; din[i] = d; rd[i] = r;
    @(posedge clock); #1;
    wr[i] = 1'b0; rd[i] = 1'b0;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic resume();
    @(posedge clock); #1;
  endtask

  bit ae_tab [6] = '{1, 1, 0, 0, 0, 0};
  bit af_tab [6] = '{0, 0, 0, 0, 0, 1};

  initial begin
    for (int i = 0; i < 3; i++) begin wr[i] = 0; rd[i] = 0; din[i] = 0; end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    sample();
    check("rst_empty", e1, 1);   check("rst_full", f1, 0);
    check("rst_count", c1, 0);   check("rst_dout", d1, 0);
    check("rst_ae", ae1, 1);     check("rst_af", af1, 0);
    check("rst_ov", ov1, 0);     check("rst_un", un1, 0);
    check("rst_vld_reg", v2, 0); check("rst_dout_reg", d2, 0);
    check("rst_vld_fwft", v0, 0);
    resume();

    // DEPTH=5: fill, overflow on the 6th write, drain in order
    for (int k = 0; k < 5; k++) begin
      q0.push_back(8'h11 + 8'(k));
      step(0, 1, 8'h11 + 8'(k), 0);
    end
    step(0, 1, 8'h66, 0);
    sample();
    check("a_full", f0, 1); check("a_count", c0, 5);
    check("a_overflow", ov0, 1); check("a_af", af0, 1);
    resume();
    for (int k = 0; k < 5; k++) step(0, 0, 8'h00, 1);
    sample();
    check("a_empty", e0, 1); check("a_count0", c0, 0);
    check("a_underflow", un0, 0); check("a_dout_empty", d0, 0);
    check("a_ae_empty", ae0, 1);
    resume();
    // both pointers have wrapped back to entry 0
    q0.push_back(8'h21);
    step(0, 1, 8'h21, 0);
    step(0, 0, 8'h00, 1);
    sample();
    check("a_wrap_empty", e0, 1);
    resume();

    // DEPTH=8 default levels: threshold crossings
    for (int k = 0; k < 6; k++) begin
      q1.push_back(8'hB0 + 8'(k));
      step(1, 1, 8'hB0 + 8'(k), 0);
      sample();
      check("b_count", c1, k + 1);
      check("b_ae", ae1, int'(ae_tab[k]));
      check("b_af", af1, int'(af_tab[k]));
      resume();
    end
    for (int k = 6; k < 8; k++) begin
      q1.push_back(8'hB0 + 8'(k));
      step(1, 1, 8'hB0 + 8'(k), 0);
    end
    sample();
    check("b_full", f1, 1); check("b_count8", c1, 8);
    resume();
    // full with simultaneous read+write
    for (int k = 0; k < 4; k++) begin
      q1.push_back(8'hA0 + 8'(k));
      step(1, 1, 8'hA0 + 8'(k), 1);
    end
    sample();
    check("b_rw_count", c1, 8); check("b_rw_full", f1, 1);
    check("b_rw_ov", ov1, 0);
    resume();
    for (int k = 0; k < 8; k++) step(1, 0, 8'h00, 1);
    sample();
    check("b_drain_empty", e1, 1); check("b_drain_un", un1, 0);
    resume();
    // empty with read+write: only the write lands
    q1.push_back(8'h5A);
    step(1, 1, 8'h5A, 1);
    sample();
    check("b_ew_count", c1, 1); check("b_ew_un", un1, 1);
    check("b_ew_dout", d1, 8'h5A); check("b_ew_vld", v1, 1);
    resume();
    for (int k = 1; k < 6; k++) begin
      q1.push_back(8'hC0 + 8'(k));
      step(1, 1, 8'hC0 + 8'(k), 0);
    end
    sample();
    check("b_pre_rst_count", c1, 6); check("b_pre_rst_af", af1, 1);
    resume();

    // registered read mode
    step(2, 1, 8'h3C, 0);
    sample();
    check("c_wr_vld", v2, 0); check("c_wr_count", c2, 1); check("c_wr_dout", d2, 0);
    resume();
    q2.push_back(8'h3C);
    step(2, 0, 8'h00, 1);
    sample();
    check("c_rd_vld", v2, 1); check("c_rd_dout", d2, 8'h3C);
    resume();
    sample();
    check("c_hold_vld", v2, 0); check("c_hold_dout", d2, 8'h3C);
    resume();
    step(2, 0, 8'h00, 1);
    sample();
    check("c_ur_vld", v2, 0); check("c_ur_un", un2, 1); check("c_ur_dout", d2, 8'h3C);
    resume();
    step(2, 1, 8'h44, 0);

    // reset wins over a concurrent read; stored words are dropped
    reset = 1'b1; rd[2] = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; rd[2] = 1'b0;
    q1.delete();
    sample();
    check("r_b_count", c1, 0);  check("r_b_empty", e1, 1);
    check("r_b_ae", ae1, 1);    check("r_b_af", af1, 0);
    check("r_b_full", f1, 0);   check("r_b_un", un1, 0);
    check("r_b_dout", d1, 0);
    check("r_c_vld", v2, 0);    check("r_c_count", c2, 0);
    check("r_c_dout", d2, 0);   check("r_c_un", un2, 0);
    check("r_a_ov", ov0, 0);
    resume();
    repeat (2) @(posedge clock);
    #1;

    check("pops0", pops0, 6);
    check("pops1", pops1, 12);
    check("pops2", pops2, 1);
    check("q0_left", q0.size(), 0);
    check("q2_left", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
